line_reader: RTL and testbench

LINE_READER -- requirements
Module: line_reader

---
 rtl/line_reader.sv | 165 ++++++++++++++++
 tb/tb_line_reader.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_reader.sv
// line_reader: fetches a burst of len bytes from a one-cycle-latency memory into a small output FIFO stream.
// Optional feature macro LINE_READER_UNDERRUN_EN adds a sticky underrun output.
module line_reader #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH-1:0] len,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
  output logic                     mem_read_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef LINE_READER_UNDERRUN_EN
  ,
  output logic                     underrun
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic                     in_flight_q, in_flight_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    fifo_q [FIFO_DEPTH];
  logic                     issue_s, push_s, pop_s;

  // A read may issue only if the FIFO can hold it alongside the one still in flight.
  assign issue_s = (state_q == FETCH) && ((count_q + CW'(in_flight_q)) < DEPTH_C);
  assign push_s  = in_flight_q;
  assign pop_s   = valid_q && out_ready;

  // Next-state logic for the burst FSM, FIFO pointers and status outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = issue_s ? addr_q + ADDRESS_WIDTH'(1) : addr_q;
    rem_d       = issue_s ? rem_q - ADDRESS_WIDTH'(1) : rem_q;
    wr_ptr_d    = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    in_flight_d = issue_s;
    done_d      = 1'b0;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          addr_d  = start_addr;
          rem_d   = len;
          state_d = FETCH;
        end else begin
          done_d = start;
        end
      end
      FETCH: begin
        if (issue_s && (rem_q == ADDRESS_WIDTH'(1))) begin
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (!in_flight_q && (count_d == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort wins over everything, including a same-cycle start
    if (abort) begin
      state_d     = IDLE;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      in_flight_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      in_flight_d = issue_s;
    end
    busy_d  = (state_d != IDLE);
    valid_d = (count_d != '0);
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_flight_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_flight_q <= in_flight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
    end
  end

  // FIFO storage; occupancy is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= mem_read_data;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mem_read_addr   = addr_q;
  assign mem_read_enable = issue_s;
  assign out_data        = fifo_q[rd_ptr_q];
  assign out_valid       = valid_q;

`ifdef LINE_READER_UNDERRUN_EN
  logic underrun_q;

  // Sticky flag: consumer was ready while the stream had nothing to offer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      underrun_q <= 1'b0;
    end else if ((state_q == IDLE) && start && !abort) begin
      underrun_q <= 1'b0;
    end else if (busy_q && out_ready && !valid_q) begin
      underrun_q <= 1'b1;
    end
  end

  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_line_reader.sv
// Self-checking bench for line_reader: directed scenarios plus randomized bursts against a queue model.
module tb_line_reader;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, out_ready;
  logic [AW-1:0] start_addr, len, mem_read_addr;
  logic          busy, done, mem_read_enable, out_valid;
  logic [DW-1:0] mem_read_data, out_data;
`ifdef LINE_READER_UNDERRUN_EN
  logic          underrun;
`endif

  always #5 clk = ~clk;

  line_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .mem_read_addr(mem_read_addr),
    .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef LINE_READER_UNDERRUN_EN
    , .underrun(underrun)
`endif
  );

  // behavioural memory with one cycle read latency
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= mem[mem_read_addr];
  end

  int n_cmp, n_err;
  int ncyc, last_hs, n_done, n_busy;
  int flow_bad, unstable, done_late, done_busy, idle_rd;
  logic          hold_v;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] got_q[$];

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    ncyc++;
    if (done) begin
      n_done++;
      if (busy) done_busy++;
      if (got_q.size() > 0 && ncyc != last_hs + 1) done_late++;
    end
    if (busy) n_busy++;
    if (mem_read_enable) begin
      rd_q.push_back(mem_read_addr);
      if (!busy) idle_rd++;
    end
    if (rd_q.size() - got_q.size() > FD) flow_bad++;
    if (hold_v && out_valid && out_data !== hold_d) unstable++;
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      last_hs = ncyc;
    end
  end

  // reference model: byte k of a burst is simply memory at (addr + k) mod 1024
  function automatic logic [7:0] model_byte(int a, int k);
    return mem[(a + k) % 1024];
  endfunction

  function automatic logic [AW-1:0] model_addr(int a, int k);
    return AW'((a + k) % 1024);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rd_q.delete();
    got_q.delete();
    n_done = 0;
    n_busy = 0;
  endtask

  task automatic do_start(input int a, input int l);
    tick();
    start = 1'b1; start_addr = AW'(a); len = AW'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic run_done(input int bound, input bit rnd, output bit to);
    int base;
    base = n_done;
    to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (busy && $urandom_range(0, 7) == 0) begin
          start = 1'b1; start_addr = AW'($urandom); len = AW'($urandom_range(1, 30));
        end else begin
          start = 1'b0;
        end
      end
      tick();
      if (n_done != base) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; len = 10'd5; start_addr = 10'h155;
    repeat (3) tick();
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, out_valid, mem_read_enable} !== 4'b0000 || mem_read_addr !== 10'd0) begin
      n_err++;
      $display("FAIL reset_state got b/d/v/re=%b%b%b%b addr=%h required 0000 addr=000",
               busy, done, out_valid, mem_read_enable, mem_read_addr);
    end
`ifdef LINE_READER_UNDERRUN_EN
    n_cmp++;
    if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %b required 0", underrun); end
`endif
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit to;
    int bad;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    clear_mon(); out_ready = 1'b1;
    do_start(16'h010, 8);
    @(negedge clk);
    n_cmp++;
    if (mem_read_enable !== 1'b1 || mem_read_addr !== 10'h010 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL first_read got re=%b addr=%h busy=%b required 1/010/1", mem_read_enable, mem_read_addr, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_c2 got out_valid=%b required 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h10) begin
      n_err++;
      $display("FAIL latency_c3 got v=%b data=%h required 1/10", out_valid, out_data);
    end
    run_done(100, 1'b0, to);
    bad = 0;
    for (int k = 0; k < 8; k++) if (k >= got_q.size() || got_q[k] !== model_byte(16, k)) bad++;
    n_cmp++;
    if (to || bad != 0 || got_q.size() != 8) begin
      n_err++; $display("FAIL basic_stream got %0d bytes %0d wrong timeout=%0d required 8/0/0", got_q.size(), bad, to);
    end
    n_cmp++;
    if (n_done != 1 || rd_q.size() != 8) begin
      n_err++; $display("FAIL basic_counts got done=%0d reads=%0d required 1/8", n_done, rd_q.size());
    end
  endtask

  task automatic test_wrap();
    bit to;
    int bad;
    clear_mon(); out_ready = 1'b1;
    do_start(10'h3FE, 4);
    run_done(100, 1'b0, to);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (k >= rd_q.size() || rd_q[k] !== model_addr(10'h3FE, k)) bad++;
      if (k >= got_q.size() || got_q[k] !== model_byte(10'h3FE, k)) bad++;
    end
    n_cmp++;
    if (to || bad != 0 || rd_q.size() != 4 || got_q.size() != 4) begin
      n_err++; $display("FAIL wrap got reads=%0d bytes=%0d wrong=%0d required 4/4/0", rd_q.size(), got_q.size(), bad);
    end
  endtask

  task automatic test_stall();
    bit to;
    int bad;
    clear_mon(); out_ready = 1'b0;
    do_start(16'h040, 16);
    repeat (10) tick();
    n_cmp++;
    if (rd_q.size() != 4 || out_valid !== 1'b1 || out_data !== model_byte(16'h040, 0)) begin
      n_err++;
      $display("FAIL stall got reads=%0d v=%b data=%h required 4/1/%h", rd_q.size(), out_valid, out_data, model_byte(16'h040, 0));
    end
    out_ready = 1'b1;
    run_done(200, 1'b0, to);
    bad = 0;
    for (int k = 0; k < 16; k++) if (k >= got_q.size() || got_q[k] !== model_byte(16'h040, k)) bad++;
    n_cmp++;
    if (to || bad != 0 || got_q.size() != 16 || n_done != 1) begin
      n_err++; $display("FAIL stall_release got bytes=%0d wrong=%0d done=%0d required 16/0/1", got_q.size(), bad, n_done);
    end
  endtask

  task automatic test_empty();
    clear_mon();
    do_start(5, 0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL empty_done got done=%b busy=%b required 1/0", done, busy);
    end
    repeat (5) tick();
    n_cmp++;
    if (n_done != 1 || rd_q.size() != 0 || n_busy != 0) begin
      n_err++; $display("FAIL empty_counts got done=%0d reads=%0d busy_cycles=%0d required 1/0/0", n_done, rd_q.size(), n_busy);
    end
  endtask

  task automatic test_abort();
    bit to;
    int bad, nr;
    clear_mon(); out_ready = 1'b1;
    do_start(200, 8);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mem_read_enable !== 1'b0) begin
      n_err++; $display("FAIL abort_state got v=%b busy=%b re=%b required 0/0/0", out_valid, busy, mem_read_enable);
    end
    repeat (5) tick();
    n_cmp++;
    if (n_done != 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses required 0", n_done); end
    clear_mon();
    do_start(300, 2);
    run_done(100, 1'b0, to);
    bad = 0;
    for (int k = 0; k < 2; k++) if (k >= got_q.size() || got_q[k] !== model_byte(300, k)) bad++;
    n_cmp++;
    if (to || bad != 0 || got_q.size() != 2) begin
      n_err++; $display("FAIL abort_restart got bytes=%0d wrong=%0d required 2/0", got_q.size(), bad);
    end
    clear_mon();
    tick();
    abort = 1'b1; start = 1'b1; start_addr = 10'd7; len = 10'd3;
    tick();
    abort = 1'b0; start = 1'b0;
    repeat (4) tick();
    nr = rd_q.size();
    n_cmp++;
    if (nr != 0 || n_busy != 0 || n_done != 0) begin
      n_err++; $display("FAIL abort_priority got reads=%0d busy=%0d done=%0d required 0/0/0", nr, n_busy, n_done);
    end
  endtask

  task automatic test_reset_midburst();
    int s;
    clear_mon(); out_ready = 1'b1;
    do_start(100, 10);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || mem_read_enable !== 1'b0 || mem_read_addr !== 10'd0) begin
      n_err++;
      $display("FAIL midreset_state got busy=%b v=%b re=%b addr=%h required 0/0/0/000", busy, out_valid, mem_read_enable, mem_read_addr);
    end
    s = rd_q.size();
    repeat (10) tick();
    n_cmp++;
    if (rd_q.size() != s || n_done != 0) begin
      n_err++; $display("FAIL midreset_quiet got extra_reads=%0d done=%0d required 0/0", rd_q.size() - s, n_done);
    end
  endtask

`ifdef LINE_READER_UNDERRUN_EN
  task automatic test_underrun();
    bit to;
    out_ready = 1'b1;
    do_start(16'h020, 4);
    run_done(100, 1'b0, to);
    repeat (2) tick();
    n_cmp++;
    if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set got %b required 1", underrun); end
    out_ready = 1'b0;
    do_start(16'h020, 2);
    @(negedge clk);
    n_cmp++;
    if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clear got %b required 0", underrun); end
    tick();
    out_ready = 1'b1;
    run_done(100, 1'b0, to);
  endtask
`endif

  task automatic test_random();
    bit to;
    int a, l, bad;
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      a = $urandom_range(0, 1023);
      l = (b % 5 == 0) ? 0 : $urandom_range(1, 20);
      clear_mon();
      out_ready = ($urandom_range(0, 1) != 0);
      do_start(a, l);
      run_done(400, 1'b1, to);
      bad = 0;
      for (int k = 0; k < l; k++) begin
        if (k >= got_q.size() || got_q[k] !== model_byte(a, k)) bad++;
        if (k >= rd_q.size() || rd_q[k] !== model_addr(a, k)) bad++;
      end
      n_cmp++;
      if (to || bad != 0 || got_q.size() != l || rd_q.size() != l || n_done != 1) begin
        n_err++;
        $display("FAIL random[%0d] addr=%h len=%0d got bytes=%0d reads=%0d wrong=%0d done=%0d timeout=%0d required %0d/%0d/0/1/0",
                 b, a, l, got_q.size(), rd_q.size(), bad, n_done, to, l, l);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (flow_bad != 0 || unstable != 0 || done_late != 0 || done_busy != 0 || idle_rd != 0) begin
      n_err++;
      $display("FAIL invariants got overfill=%0d unstable=%0d done_late=%0d done_busy=%0d idle_reads=%0d required all 0",
               flow_bad, unstable, done_late, done_busy, idle_rd);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; ncyc = 0; last_hs = 0;
    flow_bad = 0; unstable = 0; done_late = 0; done_busy = 0; idle_rd = 0;
    hold_v = 1'b0; hold_d = '0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    clear_mon();
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_empty();
    test_abort();
    test_reset_midburst();
`ifdef LINE_READER_UNDERRUN_EN
    test_underrun();
`endif
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
